// File: rtl/color_thresholding.sv
// ---------------------------------------------------------------------------
// color_thresholding
//   Scans a stored RGB frame in shared SRAM and writes a binary mask word per
//   pixel: 1 when the pixel lies inside the inclusive RGB threshold box, else 0.
//   Each pixel takes exactly three cycles (READ, EVAL, WRITE). The SRAM bus is
//   driven only while the block is enabled, so other blocks can share it.
//
// Ports
//   clk_div_by_two            in   system clock, rising edge
//   reset                     in   asynchronous, active-high
//   enable_color_thresholding in   level: high = run/hold, low = release bus, clear done
//   data_read      [31:0]     in   SRAM read data {8'h00, R, G, B}
//   threshold_min  [23:0]     in   {Rmin, Gmin, Bmin}, inclusive
//   threshold_max  [23:0]     in   {Rmax, Gmax, Bmax}, inclusive
//   wren                      out  SRAM write enable (high-Z when the bus is released)
//   data_write     [31:0]     out  SRAM write data, 32'd1 or 32'd0 (high-Z when released)
//   address        [17:0]     out  SRAM word address (high-Z when released)
//   match_count    [17:0]     out  pixels written as 1 in the current/last pass
//   color_thresholding_done   out  pass complete
// ---------------------------------------------------------------------------
module color_thresholding #(
  parameter int unsigned PIXEL_COUNT = 76800,
  parameter int unsigned SRC_BASE    = 0,
  parameter int unsigned DST_BASE    = 76800
) (
  input  logic        clk_div_by_two,
  input  logic        reset,
  input  logic        enable_color_thresholding,
  input  logic [31:0] data_read,
  input  logic [23:0] threshold_min,
  input  logic [23:0] threshold_max,
  output logic        wren,
  output logic [31:0] data_write,
  output logic [17:0] address,
  output logic [17:0] match_count,
  output logic        color_thresholding_done
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, DONE} state_t;

  localparam logic [17:0] SRC  = 18'(SRC_BASE);
  localparam logic [17:0] DST  = 18'(DST_BASE);
  localparam logic [17:0] LAST = 18'(PIXEL_COUNT - 1);

  // Both address windows must fit in the 18-bit SRAM address space.
  if (longint'(SRC_BASE) + longint'(PIXEL_COUNT) > 64'd262144) begin : g_src_range
    $error("color_thresholding: SRC_BASE + PIXEL_COUNT exceeds 2^18");
  end
  if (longint'(DST_BASE) + longint'(PIXEL_COUNT) > 64'd262144) begin : g_dst_range
    $error("color_thresholding: DST_BASE + PIXEL_COUNT exceeds 2^18");
  end
  if (PIXEL_COUNT == 0) begin : g_count_range
    $error("color_thresholding: PIXEL_COUNT must be at least 1");
  end

  state_t      state;
  logic [17:0] idx;
  logic [23:0] min_q;
  logic [23:0] max_q;
  logic        drive;
  logic        wren_q;
  logic [31:0] data_write_q;
  logic [17:0] address_q;
  logic        hit;
  logic        unused_upper;

  // The top byte of the read word carries no colour information.
  assign unused_upper = ^data_read[31:24];

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // A channel with min > max can never satisfy both compares, so such a
  // threshold box yields an all-zero mask without any special casing.
  assign hit = in_range(data_read[23:16], min_q[23:16], max_q[23:16]) &&
               in_range(data_read[15:8],  min_q[15:8],  max_q[15:8])  &&
               in_range(data_read[7:0],   min_q[7:0],   max_q[7:0]);

  // NOTE: every register below is updated with non-blocking assignments so
  // all next-state values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk_div_by_two or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      idx                     <= '0;
      min_q                   <= '0;
      max_q                   <= '0;
      drive                   <= 1'b0;
      wren_q                  <= 1'b0;
      data_write_q            <= '0;
      address_q               <= '0;
      match_count             <= '0;
      color_thresholding_done <= 1'b0;
    end else if (!enable_color_thresholding) begin
      // Abort from any state: release the bus; match_count keeps the last result.
      state                   <= IDLE;
      idx                     <= '0;
      drive                   <= 1'b0;
      wren_q                  <= 1'b0;
      color_thresholding_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          min_q       <= threshold_min;
          max_q       <= threshold_max;
          idx         <= '0;
          match_count <= '0;
          drive       <= 1'b1;
          wren_q      <= 1'b0;
          address_q   <= SRC;
          state       <= READ;
        end
        READ: begin
          // Address presented this cycle; SRAM data arrives during EVAL.
          state <= EVAL;
        end
        EVAL: begin
          address_q    <= DST + idx;
          data_write_q <= {31'b0, hit};
          wren_q       <= 1'b1;
          match_count  <= match_count + {17'b0, hit};
          state        <= WRITE;
        end
        WRITE: begin
          wren_q <= 1'b0;
          idx    <= idx + 18'd1;
          if (idx == LAST) begin
            color_thresholding_done <= 1'b1;
            state                   <= DONE;
          end else begin
            address_q <= SRC + idx + 18'd1;
            state     <= READ;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus values and the drive flag are both registered; the tri-state buffer
  // only gates them onto the shared SRAM bus.
  assign wren       = drive ? wren_q       : 1'bz;
  assign data_write = drive ? data_write_q : {32{1'bz}};
  assign address    = drive ? address_q    : {18{1'bz}};

endmodule

// File: tb/tb_color_thresholding.sv
// ---------------------------------------------------------------------------
// tb_color_thresholding
//   Directed bench for color_thresholding. Two instances with PIXEL_COUNT=4:
//   dut_a (SRC=0, DST=16) and dut_b (in place, SRC=DST=0), each with its own
//   small SRAM model (one-cycle registered read, write on wren).
// ---------------------------------------------------------------------------
module tb_color_thresholding;

  logic        clk;
  logic        reset;
  logic        en_a;
  logic        en_b;
  logic [23:0] thr_min;
  logic [23:0] thr_max;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  wire         wren_a;
  wire  [31:0] dw_a;
  wire  [17:0] addr_a;
  wire  [17:0] match_a;
  wire         done_a;
  wire         wren_b;
  wire  [31:0] dw_b;
  wire  [17:0] addr_b;
  wire  [17:0] match_b;
  wire         done_b;

  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];
  logic        ld;
  logic        ld_sel;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  int          pulses_a;
  int          pulses_b;

  int errors;
  int checks;

  color_thresholding #(.PIXEL_COUNT(4), .SRC_BASE(0), .DST_BASE(16)) dut_a (
    .clk_div_by_two            (clk),
    .reset                     (reset),
    .enable_color_thresholding (en_a),
    .data_read                 (rd_a),
    .threshold_min             (thr_min),
    .threshold_max             (thr_max),
    .wren                      (wren_a),
    .data_write                (dw_a),
    .address                   (addr_a),
    .match_count               (match_a),
    .color_thresholding_done   (done_a)
  );

  color_thresholding #(.PIXEL_COUNT(4), .SRC_BASE(0), .DST_BASE(0)) dut_b (
    .clk_div_by_two            (clk),
    .reset                     (reset),
    .enable_color_thresholding (en_b),
    .data_read                 (rd_b),
    .threshold_min             (thr_min),
    .threshold_max             (thr_max),
    .wren                      (wren_b),
    .data_write                (dw_b),
    .address                   (addr_b),
    .match_count               (match_b),
    .color_thresholding_done   (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: registered read, write when wren is high, bench preload port.
  always @(posedge clk) begin
    if (ld && !ld_sel) mem_a[ld_addr] <= ld_data;
    else if (wren_a === 1'b1) mem_a[addr_a[4:0]] <= dw_a;
    if (wren_a === 1'b1) pulses_a <= pulses_a + 1;
    rd_a <= mem_a[addr_a[4:0]];
  end

  always @(posedge clk) begin
    if (ld && ld_sel) mem_b[ld_addr] <= ld_data;
    else if (wren_b === 1'b1) mem_b[addr_b[4:0]] <= dw_b;
    if (wren_b === 1'b1) pulses_b <= pulses_b + 1;
    rd_b <= mem_b[addr_b[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A released bus reads as Z; a two-state simulator resolves it to 0.
  function automatic logic released_a();
    return (wren_a !== 1'b1) && ((addr_a === {18{1'bz}}) || (addr_a === 18'd0));
  endfunction

  function automatic logic released_b();
    return (wren_b !== 1'b1) && ((addr_b === {18{1'bz}}) || (addr_b === 18'd0));
  endfunction

  task automatic load(input bit sel, input logic [4:0] a, input logic [31:0] d);
    ld_sel  = sel;
    ld_addr = a;
    ld_data = d;
    ld      = 1'b1;
    @(negedge clk);
    ld      = 1'b0;
  endtask

  // Called at the negedge right after the IDLE->READ edge; cyc counts the
  // edges until done is seen (12 for four pixels).
  task automatic run_to_done(input bit sel, output int cyc);
    cyc = 0;
    while (!(sel ? done_b : done_a) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_src2(input bit sel);
    load(sel, 5'd0, 32'h0020_0000);
    load(sel, 5'd1, 32'h0020_4000);
    load(sel, 5'd2, 32'h0020_4100);
    load(sel, 5'd3, 32'h000F_0000);
  endtask

  task automatic clear_dst_a();
    for (int i = 16; i < 20; i++) load(1'b0, 5'(i), 32'hDEAD_BEEF);
  endtask

  task automatic check_mask_a(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_mask%0d", tag, i), mem_a[16 + i], {31'b0, exp[i]});
  endtask

  initial begin
    int cyc;
    int p0;
    int guard;
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    en_a    = 1'b0;
    en_b    = 1'b0;
    ld      = 1'b0;
    ld_sel  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    thr_min = '0;
    thr_max = '0;

    // ---- reset state
    repeat (2) @(negedge clk);
    check("rst_bus_a", {31'b0, released_a()}, 32'd1);
    check("rst_bus_b", {31'b0, released_b()}, 32'd1);
    check("rst_done", {31'b0, done_a}, 32'd0);
    check("rst_match", {14'b0, match_a}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_bus", {31'b0, released_a()}, 32'd1);

    // ---- 1: full-range box, every pixel matches
    thr_min = 24'h000000;
    thr_max = 24'hFFFFFF;
    load(1'b0, 5'd0, 32'h1234_5678);
    load(1'b0, 5'd1, 32'h0000_0000);
    load(1'b0, 5'd2, 32'hFFFF_FFFF);
    load(1'b0, 5'd3, 32'h00AB_CDEF);
    clear_dst_a();
    p0   = pulses_a;
    en_a = 1'b1;
    @(negedge clk);
    check("t1_first_addr", {14'b0, addr_a}, 32'd0);
    check("t1_first_wren", {31'b0, wren_a}, 32'd0);
    run_to_done(1'b0, cyc);
    check("t1_cycles", cyc, 32'd12);
    check("t1_match", {14'b0, match_a}, 32'd4);
    check("t1_pulses", pulses_a - p0, 32'd4);
    check_mask_a("t1", 4'b1111);
    check("t1_hold_addr", {14'b0, addr_a}, 32'd19);
    check("t1_hold_wren", {31'b0, wren_a}, 32'd0);
    check("t1_hold_data", dw_a, 32'd1);
    en_a = 1'b0;
    @(negedge clk);
    check("t1_off_bus", {31'b0, released_a()}, 32'd1);
    check("t1_off_done", {31'b0, done_a}, 32'd0);
    check("t1_off_match", {14'b0, match_a}, 32'd4);

    // ---- 2: boundary pixels against box R 10..FF, G 00..40, B 00..40
    thr_min = 24'h100000;
    thr_max = 24'hFF4040;
    load_src2(1'b0);
    clear_dst_a();
    en_a = 1'b1;
    @(negedge clk);
    run_to_done(1'b0, cyc);
    check("t2_cycles", cyc, 32'd12);
    check("t2_match", {14'b0, match_a}, 32'd2);
    check_mask_a("t2", 4'b0011);
    en_a = 1'b0;
    @(negedge clk);

    // ---- 3: in-place pass on dut_b
    load_src2(1'b1);
    p0   = pulses_b;
    en_b = 1'b1;
    @(negedge clk);
    check("t3_first_addr", {14'b0, addr_b}, 32'd0);
    run_to_done(1'b1, cyc);
    check("t3_cycles", cyc, 32'd12);
    check("t3_match", {14'b0, match_b}, 32'd2);
    check("t3_pulses", pulses_b - p0, 32'd4);
    check("t3_mask0", mem_b[0], 32'd1);
    check("t3_mask1", mem_b[1], 32'd1);
    check("t3_mask2", mem_b[2], 32'd0);
    check("t3_mask3", mem_b[3], 32'd0);
    en_b = 1'b0;
    @(negedge clk);
    check("t3_off_bus", {31'b0, released_b()}, 32'd1);

    // ---- 4: abort after the pixel 1 write, then rerun from pixel 0
    clear_dst_a();
    p0    = pulses_a;
    en_a  = 1'b1;
    guard = 0;
    while (pulses_a - p0 < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    en_a = 1'b0;
    @(negedge clk);
    check("t4_abort_bus", {31'b0, released_a()}, 32'd1);
    check("t4_abort_done", {31'b0, done_a}, 32'd0);
    check("t4_abort_match", {14'b0, match_a}, 32'd2);
    repeat (3) @(negedge clk);
    check("t4_abort_pulses", pulses_a - p0, 32'd2);
    check("t4_abort_mem18", mem_a[18], 32'hDEAD_BEEF);
    clear_dst_a();
    en_a = 1'b1;
    @(negedge clk);
    check("t4_restart_addr", {14'b0, addr_a}, 32'd0);
    check("t4_restart_wren", {31'b0, wren_a}, 32'd0);
    run_to_done(1'b0, cyc);
    check("t4_cycles", cyc, 32'd12);
    check("t4_match", {14'b0, match_a}, 32'd2);
    check_mask_a("t4", 4'b0011);
    en_a = 1'b0;
    @(negedge clk);

    // ---- 5: reset during EVAL of pixel 2
    clear_dst_a();
    p0    = pulses_a;
    en_a  = 1'b1;
    guard = 0;
    while (pulses_a - p0 < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);   // now in EVAL of pixel 2
    reset = 1'b1;
    en_a  = 1'b0;
    #1;
    check("t5_rst_bus", {31'b0, released_a()}, 32'd1);
    check("t5_rst_match", {14'b0, match_a}, 32'd0);
    check("t5_rst_done", {31'b0, done_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_pulses", pulses_a - p0, 32'd2);
    check("t5_mem18", mem_a[18], 32'hDEAD_BEEF);
    check("t5_mem17", mem_a[17], 32'd1);

    // ---- 6a: inverted R range latched, widened mid-pass -> all-zero mask
    thr_min = 24'h400000;
    thr_max = 24'h10FFFF;
    clear_dst_a();
    en_a = 1'b1;
    @(negedge clk);
    thr_min = 24'h000000;
    thr_max = 24'hFFFFFF;
    run_to_done(1'b0, cyc);
    check("t6a_cycles", cyc, 32'd12);
    check("t6a_match", {14'b0, match_a}, 32'd0);
    check_mask_a("t6a", 4'b0000);
    en_a = 1'b0;
    @(negedge clk);

    // ---- 6b: full range latched, inverted mid-pass -> all-ones mask
    clear_dst_a();
    en_a = 1'b1;
    @(negedge clk);
    thr_min = 24'h400000;
    thr_max = 24'h10FFFF;
    run_to_done(1'b0, cyc);
    check("t6b_match", {14'b0, match_a}, 32'd4);
    check_mask_a("t6b", 4'b1111);
    en_a = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
